// File: rtl/spi_frame_writer.sv
// Purpose: SPI-slave (mode 0, MSB first) pixel loader driving the frame-buffer RAM write port.
// Latency: WR_EN is registered 4 CLK cycles after the SCK pin edge that completes a 16-bit word.
// Backpressure: none; the RAM always accepts, and strobes are at least 128 CLK cycles apart.
//
// Ports: CLK/RST_N system clock and async active-low reset; SCK/SSEL/MOSI asynchronous SPI
// inputs; MISO status output ({8'hA5, FRAME_CNT}); WR_EN/WR_ADDR/WR_DATA one-cycle RAM write;
// FRAME_DONE pulses with the write of the last pixel; FRAME_CNT counts completed frames.
module spi_frame_writer #(
    parameter int          PIXELS    = 14400,
    parameter int          AW        = 15,
    parameter logic [15:0] SYNC_WORD = 16'hF000
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          SCK,
    input  logic          SSEL,
    input  logic          MOSI,
    output logic          MISO,
    output logic          WR_EN,
    output logic [AW-1:0] WR_ADDR,
    output logic [11:0]   WR_DATA,
    output logic          FRAME_DONE,
    output logic [7:0]    FRAME_CNT
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(PIXELS - 1);

    // Synchronisers; stage 0 is the metastability catcher, edges use stages [2:1].
    logic [2:0] sck_s;
    logic [2:0] ssel_s;
    logic [1:0] mosi_s;

    logic        sck_rise;
    logic        sck_fall;
    logic        ssel_fall;
    logic        active;

    assign sck_rise  =  sck_s[1] & ~sck_s[2];
    assign sck_fall  = ~sck_s[1] &  sck_s[2];
    assign ssel_fall = ~ssel_s[1] & ssel_s[2];
    assign active    = ~ssel_s[1];

    // Receive side
    logic [3:0]    bit_cnt;
    logic [15:0]   shreg;
    logic          word_vld;   // shreg holds a complete word this cycle
    logic [AW-1:0] pix_addr;

    // Transmit side
    logic [3:0]    fall_cnt;
    logic [15:0]   status;

    logic          is_sync;
    logic          is_reserved;

    assign is_sync     = (shreg == SYNC_WORD);
    assign is_reserved = (shreg[15:12] == 4'hF);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sck_s      <= 3'b000;
            ssel_s     <= 3'b111;   // idle = deselected, so reset release is not an SSEL fall
            mosi_s     <= 2'b00;
            bit_cnt    <= 4'd0;
            shreg      <= 16'd0;
            word_vld   <= 1'b0;
            pix_addr   <= '0;
            WR_EN      <= 1'b0;
            WR_ADDR    <= '0;
            WR_DATA    <= 12'd0;
            FRAME_DONE <= 1'b0;
            FRAME_CNT  <= 8'd0;
            fall_cnt   <= 4'd0;
            status     <= 16'd0;
        end else begin
            sck_s  <= {sck_s[1:0], SCK};
            ssel_s <= {ssel_s[1:0], SSEL};
            mosi_s <= {mosi_s[0], MOSI};

            // Deserialiser: a deselect discards any partial word.
            word_vld <= 1'b0;
            if (!active) begin
                bit_cnt <= 4'd0;
            end else if (sck_rise) begin
                shreg   <= {shreg[14:0], mosi_s[1]};
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd15) begin
                    word_vld <= 1'b1;
                end
            end

            // Word classification and RAM write. shreg is stable for a whole
            // SCK phase after completion, so it is read directly here.
            WR_EN      <= 1'b0;
            FRAME_DONE <= 1'b0;
            if (FRAME_DONE) begin
                FRAME_CNT <= FRAME_CNT + 8'd1;
            end
            if (word_vld) begin
                if (is_sync) begin
                    pix_addr <= '0;
                end else if (!is_reserved) begin
                    WR_EN   <= 1'b1;
                    WR_ADDR <= pix_addr;
                    WR_DATA <= shreg[11:0];
                    if (pix_addr == LAST_ADDR) begin
                        pix_addr   <= '0;
                        FRAME_DONE <= 1'b1;
                    end else begin
                        pix_addr <= pix_addr + AW'(1);
                    end
                end
            end

            // Status shifter: reload at select and at each word boundary so the
            // Pi sees a fresh {A5, count} at the start of every 16-bit word.
            if (ssel_fall) begin
                status   <= {8'hA5, FRAME_CNT};
                fall_cnt <= 4'd0;
            end else if (!active) begin
                fall_cnt <= 4'd0;
            end else if (sck_fall) begin
                fall_cnt <= fall_cnt + 4'd1;
                if (fall_cnt == 4'd15) begin
                    status <= {8'hA5, FRAME_CNT};
                end else begin
                    status <= {status[14:0], 1'b0};
                end
            end
        end
    end

    assign MISO = status[15];

endmodule

// File: tb/tb_spi_frame_writer.sv
// Purpose: self-checking bench for spi_frame_writer against a word-level reference model.
// Latency: expects each RAM write 4 CLK cycles after the 16th SCK rise of its word.
// Backpressure: none; the bench drives SPI at randomised phases of 3..5 CLK cycles.
module tb_spi_frame_writer;

    localparam int          PIXELS = 40;
    localparam int          AW     = 6;
    localparam logic [15:0] SYNC   = 16'hF000;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          SCK = 1'b0;
    logic          SSEL = 1'b1;
    logic          MOSI = 1'b0;
    logic          MISO;
    logic          WR_EN;
    logic [AW-1:0] WR_ADDR;
    logic [11:0]   WR_DATA;
    logic          FRAME_DONE;
    logic [7:0]    FRAME_CNT;

    spi_frame_writer #(.PIXELS(PIXELS), .AW(AW), .SYNC_WORD(SYNC)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .SCK        (SCK),
        .SSEL       (SSEL),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .WR_EN      (WR_EN),
        .WR_ADDR    (WR_ADDR),
        .WR_DATA    (WR_DATA),
        .FRAME_DONE (FRAME_DONE),
        .FRAME_CNT  (FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: pixel address and frame count as plain integers,
    // plus the queue of writes the RAM port should see.
    typedef struct {
        int addr;
        int data;
        int done;
    } wr_t;

    wr_t exp_q[$];
    int  rise_q[$];
    int  m_addr = 0;
    int  m_fcnt = 0;

    // Write monitor, sampled away from the active edge.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (WR_EN) begin
                if (exp_q.size() == 0 || rise_q.size() == 0) begin
                    check("unexpected_wr", 32'(WR_ADDR), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    int  r;
                    e = exp_q.pop_front();
                    r = rise_q.pop_front();
                    check("wr_addr", 32'(WR_ADDR), 32'(e.addr));
                    check("wr_data", 32'(WR_DATA), 32'(e.data));
                    check("frame_done", 32'(FRAME_DONE), 32'(e.done));
                    check("wr_latency", 32'(cyc - r), 32'd4);
                end
            end else if (FRAME_DONE) begin
                check("done_without_wr", 32'(FRAME_DONE), 32'd0);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Shift nbits of w out MSB first; MISO is sampled just before each rise.
    task automatic spi_bits(input logic [15:0] w, input int nbits, input bit track,
                            output logic [15:0] got);
        got = 16'd0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = w[15-i];
            wait_cyc($urandom_range(3, 5));
            got = {got[14:0], MISO};
            SCK = 1'b1;
            if (track && i == 15) rise_q.push_back(cyc);
            wait_cyc($urandom_range(3, 5));
            SCK = 1'b0;
        end
    endtask

    task automatic spi_word(input logic [15:0] w);
        logic [15:0] got;
        logic [15:0] st_exp;
        bit          pix;
        st_exp = {8'hA5, 8'(m_fcnt)};
        pix    = (w[15:12] != 4'hF);
        if (w == SYNC) begin
            m_addr = 0;
        end else if (pix) begin
            exp_q.push_back('{addr: m_addr, data: int'(w[11:0]), done: int'(m_addr == PIXELS - 1)});
            if (m_addr == PIXELS - 1) begin
                m_addr = 0;
                m_fcnt = (m_fcnt + 1) % 256;
            end else begin
                m_addr++;
            end
        end
        spi_bits(w, 16, pix, got);
        check("miso_status", 32'(got), 32'(st_exp));
    endtask

    task automatic sel_begin();
        SSEL = 1'b0;
        wait_cyc(4);
    endtask

    task automatic sel_end();
        wait_cyc(4);
        SSEL = 1'b1;
        wait_cyc(6);
    endtask

    function automatic logic [15:0] rand_pix();
        return 16'($urandom_range(0, 16'hEFFF));
    endfunction

    task automatic send_frame();
        int per;
        per = (PIXELS + 3) / 4;
        spi_word(SYNC);
        for (int t = 0; t < 4; t++) begin
            if (t > 0) sel_begin();
            for (int k = t * per; k < PIXELS && k < (t + 1) * per; k++) begin
                if ($urandom_range(0, 7) == 0) spi_word(16'hF000 | 16'($urandom_range(1, 16'h0FFF)));
                spi_word(rand_pix());
            end
            sel_end();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr_en"},   32'(WR_EN),      32'd0);
        check({tag, "_wr_addr"}, 32'(WR_ADDR),    32'd0);
        check({tag, "_wr_data"}, 32'(WR_DATA),    32'd0);
        check({tag, "_done"},    32'(FRAME_DONE), 32'd0);
        check({tag, "_fcnt"},    32'(FRAME_CNT),  32'd0);
        check({tag, "_miso"},    32'(MISO),       32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] junk;

        // Reset state
        wait_cyc(3);
        check_idle_outputs("reset");
        RST_N = 1'b1;
        wait_cyc(3);

        // Three-word transaction from address 0
        sel_begin();
        spi_word(16'h0F00);
        spi_word(16'h00F0);
        spi_word(16'h000F);
        sel_end();

        // Full frame split over 4 transactions, then a pixel that must land at 0
        sel_begin();
        send_frame();
        check("fcnt_after_frame1", 32'(FRAME_CNT), 32'(m_fcnt));
        sel_begin();
        spi_word(rand_pix());
        sel_end();

        // Sync restart mid-frame
        sel_begin();
        for (int k = 0; k < 10; k++) spi_word(rand_pix());
        spi_word(SYNC);
        spi_word(16'h0123);
        sel_end();

        // Reserved word, then a 9-bit partial word aborted by deselect
        sel_begin();
        spi_word(16'hF555);
        spi_bits(16'($urandom), 9, 1'b0, junk);
        sel_end();
        sel_begin();
        spi_word(rand_pix());
        sel_end();

        // Second full frame, then MISO readback across two word boundaries
        sel_begin();
        send_frame();
        check("fcnt_after_frame2", 32'(FRAME_CNT), 32'd2);
        sel_begin();
        spi_bits(16'hFFFF, 16, 1'b0, junk);
        check("miso_first16", 32'(junk), 32'hA502);
        spi_bits(16'hFFFF, 16, 1'b0, junk);
        check("miso_second16", 32'(junk), 32'hA502);
        sel_end();

        // Async reset after the 10th bit of a word
        sel_begin();
        spi_bits(rand_pix(), 10, 1'b0, junk);
        #3;
        RST_N = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        m_addr = 0;
        m_fcnt = 0;
        SSEL = 1'b1;
        wait_cyc(3);
        RST_N = 1'b1;
        wait_cyc(3);
        sel_begin();
        spi_word(16'h0ABC);
        sel_end();

        wait_cyc(20);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        check("pending_rises", 32'(rise_q.size()), 32'd0);
        check("final_fcnt", 32'(FRAME_CNT), 32'(m_fcnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
